// File: rtl/sram_bus_master_pkg.sv
// rtl/sram_bus_master_pkg.sv - shared types for the SRAM bus initiator
package sram_master_pkg;

  localparam int N_STATES = 5;

  typedef enum logic [$clog2(N_STATES)-1:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RSP     = 3'd4
  } state_t;

  // Chip select is asserted exactly in the states that run a RAM cycle.
  function automatic logic state_uses_bus(input state_t s);
    return (s == WRITE) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/sram_bus_master_if.sv
// rtl/sram_bus_master_if.sv - request/response streams between client and SRAM initiator
interface sram_bus_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_bus_master.sv
// rtl/sram_bus_master.sv - sequences valid/ready requests into single-port sync RAM cycles
module sram_bus_master
  import sram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_bus_master_if.slave      req_if,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  req_ready;
  logic                  accept;

  // Gated by rst_n so the client never sees ready while reset is held.
  assign req_ready = rst_n && ((state_q == IDLE) || (state_q == WRITE));
  assign accept    = req_if.req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          addr_d  = req_if.req_addr;
          wdata_d = req_if.req_wdata;
          state_d = req_if.req_we ? WRITE : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d     = mem_data;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (req_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    cs_d = state_uses_bus(state_d);
    we_d = (state_d == WRITE);
    oe_d = (state_d == RD_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
    end
  end

  // Master owns the data bus only during a write cycle.
  assign mem_data = we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign mem_addr         = addr_q;
  assign mem_cs           = cs_q;
  assign mem_we           = we_q;
  assign mem_oe           = oe_q;
  assign req_if.req_ready = req_ready;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// tb/tb_sram_bus_master.sv - directed and random checks of sram_bus_master against a sync RAM model
module tb_sram_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mem_addr;
  wire  [31:0] mem_data;
  logic        mem_cs, mem_we, mem_oe;

  int checks = 0;
  int failures = 0;
  int contention = 0;

  sram_bus_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_if ();

  sram_bus_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (bus_if),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with one cycle read latency.
  logic [31:0] ram [16];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    else if (mem_cs) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 32'hzzzz_zzzz;

  always @(negedge clk) if (rst_n && mem_oe && mem_we) contention++;

  logic [31:0] shadow [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [3:0] addr, input logic [31:0] data);
    logic got;
    got = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = data;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) got = 1'b1;
    end
    if (!got) check("req_accept_timeout", {63'd0, got}, 64'd1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int stall, output logic [31:0] data);
    logic got;
    got = 1'b0;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) got = 1'b1;
    end
    if (!got) check("rsp_timeout", {63'd0, got}, 64'd1);
    repeat (stall) @(negedge clk);
    data = bus_if.rsp_rdata;
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        saw_oe, done, got_rsp, acc;
    int          gap, phase, mismatches;
    logic        op_we;
    logic [3:0]  op_addr;
    logic [31:0] op_data;

    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {63'd0, bus_if.req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, bus_if.rsp_rdata}, 64'd0);
    check("rst_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
    check("rst_mem_addr", {60'd0, mem_addr}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, bus_if.req_ready}, 64'd1);

    // Reset asserted mid-write clears strobes immediately
    send_req(1'b1, 4'd9, 32'h0BAD_0BAD);
    @(negedge clk);
    check("wr_cycle_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd6);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
    check("midrst_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    check("midrst_req_ready", {63'd0, bus_if.req_ready}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rerst_idle_ready", {63'd0, bus_if.req_ready}, 64'd1);
    check("rerst_idle_cs", {63'd0, mem_cs}, 64'd0);
    @(posedge clk);
    #1;

    // Write then read with latency trace
    send_req(1'b1, 4'd3, 32'hDEAD_BEEF);
    send_req(1'b0, 4'd3, 32'h0);
    @(negedge clk);
    check("rdaddr_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd4);
    check("rdaddr_addr", {60'd0, mem_addr}, 64'd3);
    check("rdaddr_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    @(negedge clk);
    check("rddata_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd5);
    check("rddata_bus", {32'd0, mem_data}, {32'd0, 32'hDEAD_BEEF});
    check("rddata_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    @(negedge clk);
    check("rsp_valid_latency", {63'd0, bus_if.rsp_valid}, 64'd1);
    check("rsp_rdata", {32'd0, bus_if.rsp_rdata}, {32'd0, 32'hDEAD_BEEF});
    check("rsp_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
    check("rsp_req_ready", {63'd0, bus_if.req_ready}, 64'd0);
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_drop", {63'd0, bus_if.rsp_valid}, 64'd0);
    check("idle_ready", {63'd0, bus_if.req_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back writes with req_valid held
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.req_addr  = 4'(i);
      bus_if.req_wdata = 32'((i + 1) * 32'h11);
      @(negedge clk);
      check("b2b_ready", {63'd0, bus_if.req_ready}, 64'd1);
      if (i > 0) begin
        check("b2b_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd6);
        check("b2b_addr", {60'd0, mem_addr}, 64'(i - 1));
        check("b2b_data", {32'd0, mem_data}, 64'(i * 32'h11));
      end
      @(posedge clk);
      #1;
    end
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd6);
    check("b2b_last_data", {32'd0, mem_data}, 64'h44);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, 4'(i), 32'h0);
      get_rsp(0, rd);
      check("b2b_readback", {32'd0, rd}, 64'((i + 1) * 32'h11));
    end

    // Response back-pressure for 5 cycles
    send_req(1'b0, 4'd0, 32'h0);
    bus_if.rsp_ready = 1'b0;
    got_rsp = 1'b0;
    for (int i = 0; i < 20 && !got_rsp; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) got_rsp = 1'b1;
    end
    check("bp_rsp_seen", {63'd0, got_rsp}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {63'd0, bus_if.rsp_valid}, 64'd1);
      check("bp_rdata", {32'd0, bus_if.rsp_rdata}, 64'h11);
      check("bp_ready", {63'd0, bus_if.req_ready}, 64'd0);
      check("bp_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
    end
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus_if.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_released", {63'd0, bus_if.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Read immediately followed by write to the same address
    send_req(1'b1, 4'd5, 32'h1234_5678);
    bus_if.rsp_ready = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 4'd5;
    phase = 0; gap = 0; saw_oe = 1'b0; done = 1'b0; got_rsp = 1'b0; rd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mem_oe) begin
        saw_oe = 1'b1;
        gap = 0;
      end else if (saw_oe && !mem_cs) begin
        gap++;
      end
      if (saw_oe && mem_cs && mem_we) done = 1'b1;
      if (bus_if.rsp_valid) begin
        rd = bus_if.rsp_rdata;
        got_rsp = 1'b1;
      end
      acc = bus_if.req_valid && bus_if.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (phase == 0) begin
          bus_if.req_we    = 1'b1;
          bus_if.req_wdata = 32'hA5A5_A5A5;
          phase = 1;
        end else begin
          bus_if.req_valid = 1'b0;
          phase = 2;
        end
      end
    end
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b0;
    check("rw_write_seen", {63'd0, done}, 64'd1);
    check("rw_rsp_seen", {63'd0, got_rsp}, 64'd1);
    check("rw_old_value", {32'd0, rd}, 64'h1234_5678);
    check("rw_turnaround", {63'd0, (gap >= 1)}, 64'd1);
    send_req(1'b0, 4'd5, 32'h0);
    get_rsp(1, rd);
    check("rw_new_value", {32'd0, rd}, 64'hA5A5_A5A5);

    // Random mixed traffic against a shadow memory
    for (int a = 0; a < 16; a++) begin
      op_data = $urandom;
      send_req(1'b1, 4'(a), op_data);
      shadow[a] = op_data;
    end
    mismatches = 0;
    for (int n = 0; n < 1000; n++) begin
      op_we   = 1'($urandom_range(0, 1));
      op_addr = 4'($urandom_range(0, 15));
      op_data = $urandom;
      if (op_we) begin
        send_req(1'b1, op_addr, op_data);
        shadow[op_addr] = op_data;
      end else begin
        send_req(1'b0, op_addr, op_data);
        get_rsp($urandom_range(0, 2), rd);
        if (rd !== shadow[op_addr]) mismatches++;
      end
    end
    check("random_mismatches", 64'(mismatches), 64'd0);
    check("oe_we_overlap", 64'(contention), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
